sprite_mem_arbiter: RTL and testbench

Shares the single-port sprite attribute RAM between the CPU pipeline and the GPU render engine. The CPU side is driven by the decode stage's sprite controls:
- writes: ACT/LD/MAP/TM
- reads: RD/CORD

The GPU side issues read bursts while scanning sprites. The block grants one access per cycle and stalls the CPU when it loses. It routes read data back to the owner and bounds starvation in both directions.

---
 rtl/sprite_arb_pkg.sv | 20 ++
 rtl/sprite_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite attribute RAM arbiter.
// Holds the arbitration states, the read-owner tags and the default fairness limits.
package sprite_arb_pkg;

  typedef enum logic {
    ARB,
    GPU_BURST
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_GPU
  } owner_e;

  localparam int DEF_MAX_BURST    = 4;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int ACTION_W         = 4;

endpackage

// File: rtl/sprite_mem_arbiter.sv
// Single-port sprite RAM arbiter between the CPU decode stage and the GPU renderer.
// GPU bursts are capped so a waiting CPU gets in, and CPU traffic cannot starve the GPU.
module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_re,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [ACTION_W-1:0] cpu_action,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic                gpu_req,
  input  logic [ADDR_W-1:0]   gpu_addr,
  output logic                gpu_gnt,
  output logic [DATA_W-1:0]   gpu_rdata,
  output logic                gpu_rvalid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [ACTION_W-1:0] mem_action,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BURST_W  = $clog2(MAX_BURST + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  owner_e              owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                cpu_req;
  logic                cpu_win;
  logic                gpu_win;

  assign cpu_req = cpu_re | cpu_we;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    starve_d = starve_q;
    cpu_win  = 1'b0;
    gpu_win  = 1'b0;
    if (state_q == GPU_BURST && gpu_req) begin
      if (cpu_req && burst_q == BURST_MAX) begin
        cpu_win  = 1'b1;
        state_d  = ARB;
        burst_d  = '0;
        starve_d = STARVE_W'(1);
      end else begin
        gpu_win = 1'b1;
        if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
      end
    end else begin
      // A burst whose GPU request dropped falls back to plain arbitration this cycle.
      state_d = ARB;
      burst_d = '0;
      if (gpu_req && starve_q == STARVE_MAX) begin
        gpu_win  = 1'b1;
        state_d  = GPU_BURST;
        burst_d  = BURST_W'(1);
        starve_d = '0;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
        if (!gpu_req)                 starve_d = '0;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
      end else if (gpu_req) begin
        gpu_win  = 1'b1;
        state_d  = GPU_BURST;
        burst_d  = BURST_W'(1);
        starve_d = '0;
      end else begin
        starve_d = '0;
      end
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_win;
  assign gpu_gnt    = gpu_win;
  assign mem_en     = cpu_win | gpu_win;
  assign mem_we     = cpu_win & cpu_we;
  assign mem_addr   = cpu_win ? cpu_addr : (gpu_win ? gpu_addr : '0);
  assign mem_action = cpu_win ? cpu_action : '0;
  assign mem_wdata  = cpu_win ? cpu_wdata : '0;

  // A combined read+write from the CPU is a write and returns nothing.
  assign owner_d = gpu_win ? OWN_GPU :
                   (cpu_win && !cpu_we) ? OWN_CPU : OWN_NONE;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      burst_q  <= '0;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      if (owner_q == OWN_CPU) rdata_q <= mem_rdata;
    end
  end

  // Return data shows up in the cycle after the grant, then stays held for the CPU.
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign gpu_rvalid = (owner_q == OWN_GPU);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : rdata_q;
  assign gpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter: writes, reads, burst cap, starvation bound, reset.
module tb_sprite_mem_arbiter;
  import sprite_arb_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic                clk;
  logic                rst_n;
  logic                cpu_re, cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [ACTION_W-1:0] cpu_action;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_stall;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                cpu_rvalid;
  logic                gpu_req;
  logic [ADDR_W-1:0]   gpu_addr;
  logic                gpu_gnt;
  logic [DATA_W-1:0]   gpu_rdata;
  logic                gpu_rvalid;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ACTION_W-1:0] mem_action;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sprite_mem_arbiter #(
    .MAX_BURST(4), .STARVE_LIMIT(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_action(cpu_action), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt),
    .gpu_rdata(gpu_rdata), .gpu_rvalid(gpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_action(mem_action), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_action = '0; cpu_wdata = '0;
    gpu_req = 1'b0; gpu_addr = '0;
  endtask

  initial begin
    int stalls, gpus, won_cycle, run, max_run;
    logic exp_gpu;

    idle_inputs();
    mem_rdata = '0;
    rst_n = 1'b0;

    // Reset state
    #2;
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_gpu_rvalid", gpu_rvalid, 1'b0);
    check("rst_cpu_rdata",  cpu_rdata,  '0);
    check("rst_mem_en",     mem_en,     1'b0);
    check("rst_cpu_stall",  cpu_stall,  1'b0);
    check("rst_gpu_gnt",    gpu_gnt,    1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // CPU write alone completes in the grant cycle
    cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 32'hA5; cpu_action = 4'h3;
    #1;
    check("wr_mem_en",     mem_en,     1'b1);
    check("wr_mem_we",     mem_we,     1'b1);
    check("wr_mem_addr",   mem_addr,   8'h12);
    check("wr_mem_wdata",  mem_wdata,  32'hA5);
    check("wr_mem_action", mem_action, 4'h3);
    check("wr_cpu_stall",  cpu_stall,  1'b0);
    tick();
    idle_inputs();
    #1;
    check("wr_no_rvalid", cpu_rvalid, 1'b0);
    check("idle_mem_en",  mem_en,     1'b0);

    // CPU read alone: data returns next cycle and is then held
    cpu_re = 1'b1; cpu_addr = 8'h34;
    #1;
    check("rd_mem_we",    mem_we,    1'b0);
    check("rd_mem_addr",  mem_addr,  8'h34);
    check("rd_mem_wdata", mem_wdata, '0);
    check("rd_cpu_stall", cpu_stall, 1'b0);
    tick();
    idle_inputs();
    mem_rdata = 32'h1234;
    #1;
    check("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    check("rd_cpu_rdata",  cpu_rdata,  32'h1234);
    check("rd_gpu_rvalid", gpu_rvalid, 1'b0);
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rd_rvalid_pulse", cpu_rvalid, 1'b0);
    check("rd_rdata_held",   cpu_rdata,  32'h1234);

    // Simultaneous read and write is a write with no return
    cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'h99;
    #1;
    check("rw_mem_we", mem_we, 1'b1);
    tick();
    idle_inputs();
    mem_rdata = 32'h5555;
    #1;
    check("rw_no_rvalid",    cpu_rvalid, 1'b0);
    check("rw_rdata_held",   cpu_rdata,  32'h1234);
    tick();

    // Burst cap: GPU starts a burst, CPU arrives in burst cycle 1
    gpu_req = 1'b1; gpu_addr = 8'h40;
    #1;
    check("burst_c0_gnt",  gpu_gnt,  1'b1);
    check("burst_c0_addr", mem_addr, 8'h40);
    check("burst_c0_we",   mem_we,   1'b0);
    tick();
    cpu_re = 1'b1; cpu_addr = 8'h50;
    mem_rdata = 32'hBEEF;
    #1;
    check("burst_gpu_rvalid", gpu_rvalid, 1'b1);
    check("burst_gpu_rdata",  gpu_rdata,  32'hBEEF);
    check("burst_cpu_rvalid", cpu_rvalid, 1'b0);
    stalls = 0; gpus = 0; won_cycle = -1;
    for (int c = 1; c <= 8; c++) begin
      if (cpu_stall) stalls++;
      if (gpu_gnt) gpus++;
      if (!cpu_stall) begin
        won_cycle = c;
        break;
      end
      tick();
    end
    check("burst_cpu_win_cycle", won_cycle, 4);
    check("burst_stall_cycles",  stalls,    3);
    check("burst_gpu_cycles",    gpus,      3);
    check("burst_cpu_addr",      mem_addr,  8'h50);
    tick();
    idle_inputs();
    mem_rdata = 32'h77;
    #1;
    check("burst_cpu_rvalid_ret", cpu_rvalid, 1'b1);
    check("burst_cpu_rdata_ret",  cpu_rdata,  32'h77);
    tick();

    // Starvation bound: both sides request every cycle (CPU writes)
    cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 32'h1;
    gpu_req = 1'b1; gpu_addr = 8'h70;
    #1;
    run = 0; max_run = 0;
    for (int c = 0; c < 24; c++) begin
      exp_gpu = (c >= 8 && c < 12) || (c >= 20);
      check($sformatf("starve_gnt_c%0d", c),   gpu_gnt,   exp_gpu);
      check($sformatf("starve_stall_c%0d", c), cpu_stall, exp_gpu);
      if (gpu_gnt) run = 0;
      else run++;
      if (run > max_run) max_run = run;
      tick();
    end
    check("starve_max_denied", max_run, 8);
    idle_inputs();
    tick();

    // Reset right after a GPU read grant drops the pending return
    gpu_req = 1'b1; gpu_addr = 8'h11;
    #1;
    check("rst_gpu_gnt_pre", gpu_gnt, 1'b1);
    tick();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_gpu_rvalid", gpu_rvalid, 1'b0);
    check("midrst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("midrst_cpu_rdata",  cpu_rdata,  '0);
    check("midrst_mem_en",     mem_en,     1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("postrst_gpu_rvalid", gpu_rvalid, 1'b0);
    // From ARB with a cleared starve count the CPU must win a tie
    cpu_re = 1'b1; cpu_addr = 8'h21; gpu_req = 1'b1; gpu_addr = 8'h22;
    #1;
    check("postrst_cpu_stall", cpu_stall, 1'b0);
    check("postrst_gpu_gnt",   gpu_gnt,   1'b0);
    check("postrst_mem_addr",  mem_addr,  8'h21);
    tick();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
